serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Sequencing controller for a bit-serial adder. Accepts two parallel WIDTH-bit operands and a carry-in through a valid/ready handshake, then feeds them LSB-first through an internal one-bit full adder with a carry register, one bit per clock. It reassembles the serial sum into a parallel result and presents it with carry-out through a second valid/ready handshake. It sits between a parallel producer and a consumer that want a bit-serial add without managing bit timing.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 1 to 32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b and cin are valid.
- in_ready  output  1  controller can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for bit 0.
- out_valid  output  1  sum and cout hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  parallel sum, registered.
- cout  output  1  carry out of bit WIDTH-1, registered.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch a and b into shift registers and cin into the carry register, clear the bit counter, and go to RUN.
- RUN:
  - Each cycle, s = a_sh[0]^b_sh[0]^carry.
  - carry <= majority(a_sh[0], b_sh[0], carry).
  - s shifts into the MSB of the result shift register, which shifts right.
  - a_sh and b_sh shift right; the counter increments.
  - After the WIDTH-th bit (counter==WIDTH-1), load sum <= final result register and cout <= final carry, then go to DONE.
- DONE:
  - out_valid=1.
  - On out_ready, go to IDLE.
  - sum and cout hold.
- in_ready=0 in RUN and DONE. in_valid in those states is ignored, with no queuing.
- sum and cout change only on the RUN->DONE transition. They hold their values through IDLE until the next result.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Exact, no overflow flag.
- Counter width is clog2(WIDTH), minimum 1 bit.
- For WIDTH=1, RUN lasts exactly one cycle.
- Reset asserted at any time, including mid-RUN or in DONE:
  - Aborts the operation; state returns to IDLE.
  - in_ready=1; out_valid, busy, sum, cout, the carry register and the counter all go to 0.
  - A partial result is never presented.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
- Input handshake at rising edge k. busy rises and in_ready falls after edge k.
- Bits 0..WIDTH-1 are processed at edges k+1..k+WIDTH.
- out_valid rises after edge k+WIDTH, giving a latency of WIDTH cycles from acceptance.
- Output handshake at edge m (out_valid&out_ready). out_valid and busy fall and in_ready rises after edge m.
- If out_ready is already high when DONE is entered, DONE lasts exactly one cycle.
- Peak throughput is one add per WIDTH+2 cycles. A new accept is possible at edge m+1 at the earliest.
- out_valid and the result stay stable while out_ready=0, for an unbounded stall.
- No combinational path from any input to any output. in_ready, out_valid and busy decode the state register only.

## Test plan
- WIDTH=8: a=0x5A, b=0x3C, cin=0, out_ready=1 -> out_valid 8 cycles after accept, sum=0x96, cout=0, one-cycle DONE, in_ready back high.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: a=0x12, b=0x34, out_ready=0 for 5 cycles after out_valid -> sum=0x46 and out_valid held stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
- in_valid held high with a=0xAA, b=0x55 pulsed during RUN -> ignored; the result matches the first accepted operands only.
- rst_n low during RUN bit 3 of a=0x0F+b=0x01 -> immediate IDLE, all outputs 0, no out_valid; next add 0x0F+0x01 -> sum=0x10.
- WIDTH=1 instance: a=1, b=1, cin=1 -> out_valid 1 cycle after accept, sum=1, cout=1.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: valid/ready wrapped bit-serial adder, LSB-first, one bit per clock
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_a, r_b, r_res, r_sum, w_res;
   logic [CW-1:0]    r_cnt;
   logic             r_carry, r_cout, w_s, w_c, w_last;
   assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
   assign w_c    = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
   assign w_res  = (r_res >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
   assign w_last = r_cnt == CW'(WIDTH - 1);
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = in_valid ? RUN : IDLE;
         RUN:     w_next = w_last ? DONE : RUN;
         DONE:    w_next = out_ready ? IDLE : DONE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
         end
         if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_c;
            r_res   <= w_res;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
               r_sum  <= w_res;
               r_cout <= w_c;
            end
         end
      end
   end
   assign in_ready  = r_state == IDLE;
   assign out_valid = r_state == DONE;
   assign busy      = r_state != IDLE;
   assign sum       = r_sum;
   assign cout      = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for WIDTH=8 and WIDTH=1 serial adder instances
module tb_serial_add_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
   logic [7:0] a = '0, b = '0, sum;
   logic       in_ready, out_valid, busy, cout;
   logic       in_valid1 = 1'b0, out_ready1 = 1'b0, cin1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0, sum1;
   logic       in_ready1, out_valid1, busy1, cout1;
   logic [8:0] sb[$];
   logic [1:0] sb1[$];
   int         n_vec = 0, n_err = 0;
   always #5 clk = ~clk;
   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy));
   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .cout(cout1), .busy(busy1));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic run_add(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input int stall, input bit hold);
      logic [8:0] e;
      int n;
      @(negedge clk);
      check("in_ready_idle", 32'(in_ready), 32'd1);
      out_ready = (stall == 0);
      a = ta; b = tb; cin = tc; in_valid = 1'b1;
      sb.push_back(9'(ta) + 9'(tb) + 9'(tc));
      @(posedge clk);
      @(negedge clk);
      if (hold) begin
         a = 8'hAA; b = 8'h55; cin = 1'b1;
      end else in_valid = 1'b0;
      check("busy_run", 32'({busy, in_ready}), 32'b10);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      check("latency", 32'(n), 32'd8);
      e = sb.pop_front();
      check("result", 32'({cout, sum}), 32'(e));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("stall_hold", 32'({out_valid, in_ready, cout, sum}), 32'({2'b10, e}));
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("post_handshake", 32'({out_valid, in_ready, busy, cout, sum}), 32'({3'b010, e}));
   endtask
   initial begin
      int n;
      bit seen;
      #2 rst_n = 1'b0;
      #20;
      check("reset_state", 32'({in_ready, out_valid, busy, cout, sum}), 32'({3'b100, 9'h0}));
      @(negedge clk) rst_n = 1'b1;
      run_add(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
      run_add(8'hFF, 8'h01, 1'b0, 0, 1'b0);
      run_add(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
      run_add(8'h12, 8'h34, 1'b0, 5, 1'b0);
      for (int i = 0; i < 6; i++)
         run_add(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
      run_add(8'h21, 8'h43, 1'b0, 0, 1'b1);
      @(negedge clk);
      out_ready = 1'b1;
      a = 8'h0F; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
      sb.push_back(9'h010);
      @(posedge clk);
      @(negedge clk) in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("reset_abort", 32'({in_ready, out_valid, busy, cout, sum}), 32'({3'b100, 9'h0}));
      void'(sb.pop_back());
      @(negedge clk) rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         seen |= out_valid;
      end
      check("no_partial", 32'(seen), 32'd0);
      run_add(8'h0F, 8'h01, 1'b0, 0, 1'b0);
      @(negedge clk);
      check("w1_ready", 32'(in_ready1), 32'd1);
      a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; in_valid1 = 1'b1; out_ready1 = 1'b1;
      sb1.push_back(2'b11);
      @(posedge clk);
      @(negedge clk) in_valid1 = 1'b0;
      n = 0;
      while (!out_valid1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("w1_latency", 32'(n), 32'd1);
      check("w1_result", 32'({cout1, sum1}), 32'(sb1.pop_front()));
      @(negedge clk);
      check("w1_post", 32'({out_valid1, in_ready1, busy1}), 32'b010);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end
endmodule
